// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential add-and-shift multiplier:
// FSM state encodings and the iteration-counter width helper.
package seq_mult_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADD   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_NEG   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ADD   = ST_ADD,
        SHIFT = ST_SHIFT,
        NEG   = ST_NEG,
        DONE  = ST_DONE
    } state_e;

    // Counter must hold the value WIDTH_B itself, hence the +1.
    function automatic int unsigned cnt_width(input int unsigned width_b);
        return $clog2(width_b + 1);
    endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Combinational two's-complement magnitude with sign bit, gated by signed mode.
// The most-negative input maps to 2^(W-1), which is representable unsigned in W bits.
module seq_mult_abs #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_value,
    input  logic         i_signed_mode,
    output logic [W-1:0] o_mag,
    output logic         o_neg
);

    assign o_neg = i_signed_mode & i_value[W-1];
    assign o_mag = o_neg ? (~i_value + W'(1)) : i_value;

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential add-and-shift multiplier with start/ready/done handshake.
// Operands are multiplied as magnitudes; a final negate applies the sign in signed mode.
// Optional macro SEQ_MULT_EARLY_TERM_EN: leave the shift loop as soon as the remaining
// multiplier is zero (data-dependent latency, identical products).
// All state updates on the falling clock edge.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH_A = 8,
    parameter int unsigned WIDTH_B = 8,
    parameter int unsigned PW      = WIDTH_A + WIDTH_B
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH_A-1:0] a_in,
    input  logic [WIDTH_B-1:0] b_in,
    output logic [PW-1:0]      r,
    output logic               ready,
    output logic               done
);

    localparam int unsigned CW = cnt_width(WIDTH_B);

    state_e             r_state;
    state_e             w_state_next;
    logic [PW-1:0]      r_a;
    logic [PW-1:0]      r_prod;
    logic [WIDTH_B-1:0] r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_sign;

    logic [WIDTH_A-1:0] w_a_mag;
    logic [WIDTH_B-1:0] w_b_mag;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH_B-1:0] w_b_shift;
    logic               w_last;

    seq_mult_abs #(.W(WIDTH_A)) u_abs_a (
        .i_value      (a_in),
        .i_signed_mode(signed_mode),
        .o_mag        (w_a_mag),
        .o_neg        (w_a_neg)
    );

    seq_mult_abs #(.W(WIDTH_B)) u_abs_b (
        .i_value      (b_in),
        .i_signed_mode(signed_mode),
        .o_mag        (w_b_mag),
        .o_neg        (w_b_neg)
    );

    // Multiplier value after this SHIFT, and whether this SHIFT ends the loop.
    always_comb begin
        w_b_shift = r_b >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        w_last    = (r_cnt == CW'(1)) || (w_b_shift == '0);
`else
        w_last    = (r_cnt == CW'(1));
`endif
    end

    // State register.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_b_mag[0] ? ADD : SHIFT;
                end
            end
            ADD:   w_state_next = SHIFT;
            SHIFT: begin
                if (!w_last) begin
                    w_state_next = w_b_shift[0] ? ADD : SHIFT;
                end else begin
                    // Zero product never gets negated, so -0 cannot appear.
                    w_state_next = (r_sign && (r_prod != '0)) ? NEG : DONE;
                end
            end
            NEG:     w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture on accepted start, accumulate, shift, sign-correct.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_prod <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a    <= {{WIDTH_B{1'b0}}, w_a_mag};
                        r_b    <= w_b_mag;
                        r_cnt  <= CW'(WIDTH_B);
                        r_sign <= w_a_neg ^ w_b_neg;
                        r_prod <= '0;
                    end
                end
                ADD: r_prod <= r_prod + r_a;
                SHIFT: begin
                    r_a   <= r_a << 1;
                    r_b   <= w_b_shift;
                    r_cnt <= r_cnt - CW'(1);
                end
                NEG:     r_prod <= ~r_prod + PW'(1);
                default: ;
            endcase
        end
    end

    assign r     = r_prod;
    assign ready = (r_state == IDLE);
    assign done  = (r_state == DONE);

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: 8x8 instance plus a 16x4 instance.
// Latency counts the start edge as edge 1, up to the edge that enters DONE.
module tb_seq_mult_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic [15:0] r;
    logic        ready;
    logic        done;

    logic        start2 = 1'b0;
    logic        sm2 = 1'b0;
    logic [15:0] a2 = '0;
    logic [3:0]  b2 = '0;
    logic [19:0] r2;
    logic        ready2;
    logic        done2;

    int checks = 0;
    int failures = 0;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam int LatNeg35 = 7;
    localparam int LatM7x0  = 2;
    localparam int Lat9x1   = 3;
`else
    localparam int LatNeg35 = 12;
    localparam int LatM7x0  = 9;
    localparam int Lat9x1   = 10;
`endif

    seq_mult_param #(.WIDTH_A(8), .WIDTH_B(8)) dut (
        .clock(clock), .reset(reset), .start(start), .signed_mode(signed_mode),
        .a_in(a_in), .b_in(b_in), .r(r), .ready(ready), .done(done)
    );

    seq_mult_param #(.WIDTH_A(16), .WIDTH_B(4)) dut_wide (
        .clock(clock), .reset(reset), .start(start2), .signed_mode(sm2),
        .a_in(a2), .b_in(b2), .r(r2), .ready(ready2), .done(done2)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one operation on the 8x8 DUT; returns latency (-1 on timeout) and
    // whether ready was seen high while busy. Returns at the posedge where done=1.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          output int lat, output logic rdy_hi);
        logic found;
        found  = 1'b0;
        rdy_hi = 1'b0;
        @(posedge clock);
        a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
        @(negedge clock);
        #1 start = 1'b0;
        lat = 1;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clock);
            if (done) found = 1'b1;
            else begin
                if (ready) rdy_hi = 1'b1;
                @(negedge clock);
                lat++;
            end
        end
        if (!found) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clock);
        checks++; if (r !== 16'h0) begin failures++;
            $display("FAIL reset_r: got %h expected 0000", r); end
        checks++; if (ready !== 1'b1) begin failures++;
            $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat; logic rh;
        run_op(8'd255, 8'd255, 1'b0, lat, rh);
        checks++; if (r !== 16'hFE01) begin failures++;
            $display("FAIL u255x255_r: got %h expected fe01", r); end
        checks++; if (lat !== 17) begin failures++;
            $display("FAIL u255x255_lat: got %0d expected 17", lat); end
        checks++; if (rh !== 1'b0) begin failures++;
            $display("FAIL u255x255_ready_busy: got %b expected 0", rh); end
        repeat (3) @(posedge clock);
        checks++; if (r !== 16'hFE01) begin failures++;
            $display("FAIL u255x255_hold: got %h expected fe01", r); end
        checks++; if (done !== 1'b0 || ready !== 1'b1) begin failures++;
            $display("FAIL u255x255_idle: got done=%b ready=%b expected 0 1", done, ready); end
    endtask

    task automatic test_signed();
        int lat; logic rh;
        run_op(8'hFD, 8'd5, 1'b1, lat, rh);
        checks++; if (r !== 16'hFFF1) begin failures++;
            $display("FAIL sm3x5_r: got %h expected fff1", r); end
        checks++; if (lat !== LatNeg35) begin failures++;
            $display("FAIL sm3x5_lat: got %0d expected %0d", lat, LatNeg35); end
        run_op(8'h80, 8'h80, 1'b1, lat, rh);
        checks++; if (r !== 16'h4000) begin failures++;
            $display("FAIL sm128xm128_r: got %h expected 4000", r); end
        checks++; if (lat !== 10) begin failures++;
            $display("FAIL sm128xm128_lat: got %0d expected 10", lat); end
    endtask

    task automatic test_zero();
        int lat; logic rh;
        run_op(8'hF9, 8'h00, 1'b1, lat, rh);
        checks++; if (r !== 16'h0) begin failures++;
            $display("FAIL sm7x0_r: got %h expected 0000", r); end
        checks++; if (lat !== LatM7x0) begin failures++;
            $display("FAIL sm7x0_lat: got %0d expected %0d", lat, LatM7x0); end
        @(posedge clock);
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL sm7x0_single_done: got %b expected 0", done); end
        run_op(8'h00, 8'hAA, 1'b0, lat, rh);
        checks++; if (r !== 16'h0 || lat < 0) begin failures++;
            $display("FAIL u0xaa_r: got %h lat %0d expected 0000", r, lat); end
    endtask

    task automatic test_busy();
        logic found;
        @(posedge clock);
        a_in = 8'd12; b_in = 8'd10; signed_mode = 1'b0; start = 1'b1;
        @(negedge clock);
        #1 a_in = 8'd99; b_in = 8'd77;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clock);
            if (done) found = 1'b1; else @(negedge clock);
        end
        checks++; if (r !== 16'd120 || !found) begin failures++;
            $display("FAIL busy_first: got %h found=%b expected 0078", r, found); end
        @(posedge clock);
        checks++; if (ready !== 1'b1 || r !== 16'd120) begin failures++;
            $display("FAIL busy_idle: got ready=%b r=%h expected 1 0078", ready, r); end
        @(posedge clock);
        checks++; if (ready !== 1'b0 || r !== 16'h0) begin failures++;
            $display("FAIL busy_accept: got ready=%b r=%h expected 0 0000", ready, r); end
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clock);
            if (done) found = 1'b1;
        end
        checks++; if (r !== 16'h1DC7 || !found) begin failures++;
            $display("FAIL busy_second: got %h found=%b expected 1dc7", r, found); end
    endtask

    task automatic test_reset_mid();
        int lat; logic rh;
        @(posedge clock);
        a_in = 8'd200; b_in = 8'd3; signed_mode = 1'b0; start = 1'b1;
        @(negedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        @(posedge clock);
        reset = 1'b0;
        #1;
        checks++; if (r !== 16'h0 || ready !== 1'b1 || done !== 1'b0) begin failures++;
            $display("FAIL reset_mid: got r=%h ready=%b done=%b expected 0000 1 0",
                     r, ready, done); end
        @(posedge clock);
        reset = 1'b1;
        run_op(8'd200, 8'd3, 1'b0, lat, rh);
        checks++; if (r !== 16'd600) begin failures++;
            $display("FAIL reset_mid_rerun: got %h expected 0258", r); end
    endtask

    task automatic test_early_term();
        int lat; logic rh;
        run_op(8'd9, 8'd1, 1'b0, lat, rh);
        checks++; if (r !== 16'd9) begin failures++;
            $display("FAIL et9x1_r: got %h expected 0009", r); end
        checks++; if (lat !== Lat9x1) begin failures++;
            $display("FAIL et9x1_lat: got %0d expected %0d", lat, Lat9x1); end
    endtask

    task automatic test_wide();
        logic found;
        int lat;
        @(posedge clock);
        a2 = 16'hFFFF; b2 = 4'hF; sm2 = 1'b0; start2 = 1'b1;
        @(negedge clock);
        #1 start2 = 1'b0;
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clock);
            if (done2) found = 1'b1;
            else begin @(negedge clock); lat++; end
        end
        checks++; if (r2 !== 20'hEFFF1) begin failures++;
            $display("FAIL wide_r: got %h expected efff1", r2); end
        checks++; if (lat !== 9 || !found) begin failures++;
            $display("FAIL wide_lat: got %0d expected 9", lat); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_busy();
        test_reset_mid();
        test_early_term();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
